// File: rtl/mem_trace_pkg.sv
// Shared widths and entry layouts for the memory trace collector.
package mem_trace_pkg;

  localparam int NUM_LANES = 4;
  localparam int SOURCE_W  = 32;
  localparam int ADDR_W    = 64;
  localparam int DATA_W    = 64;
  localparam int SIZE_W    = 8;
  localparam int CYCLE_W   = 64;
  localparam int DROP_W    = 32;

  // One lane's captured beat.
  typedef struct packed {
    logic [SOURCE_W-1:0] source;
    logic [ADDR_W-1:0]   address;
    logic                is_store;
    logic [SIZE_W-1:0]   size;
    logic [DATA_W-1:0]   data;
  } lane_entry_t;

  // One snapshot: every lane that fired in a single cycle, lane 0 in the low bits.
  typedef struct packed {
    logic [NUM_LANES-1:0]          mask;
    lane_entry_t [NUM_LANES-1:0]   lanes;
    logic [CYCLE_W-1:0]            cycle;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  // Saturating increment for the drop counter.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/mem_trace_collector_if.sv
// Snooped per-lane channel plus the logger-facing trace channel.
//
// Handshake semantics: a snooped lane transfers a beat when snoop_valid and
// snoop_ready are both high at a rising clock edge; the collector only observes
// these and never pushes back. On the logger side trace_log_valid is a non-zero
// lane mask whenever an entry is held, it and all fields stay stable until the
// edge where trace_log_ready is high, and that edge consumes the head entry.
interface mem_trace_collector_if;
  import mem_trace_pkg::*;

  logic [NUM_LANES-1:0]          snoop_valid;
  logic [NUM_LANES-1:0]          snoop_ready;
  logic [SOURCE_W*NUM_LANES-1:0] snoop_source;
  logic [ADDR_W*NUM_LANES-1:0]   snoop_address;
  logic [NUM_LANES-1:0]          snoop_is_store;
  logic [SIZE_W*NUM_LANES-1:0]   snoop_size;
  logic [DATA_W*NUM_LANES-1:0]   snoop_data;

  logic [NUM_LANES-1:0]          trace_log_valid;
  logic [SOURCE_W*NUM_LANES-1:0] trace_log_source;
  logic [ADDR_W*NUM_LANES-1:0]   trace_log_address;
  logic [NUM_LANES-1:0]          trace_log_is_store;
  logic [SIZE_W*NUM_LANES-1:0]   trace_log_size;
  logic [DATA_W*NUM_LANES-1:0]   trace_log_data;
  logic [CYCLE_W-1:0]            trace_log_cycle;
  logic                          trace_log_ready;

  // Core/coalescer and logger side.
  modport master (
    output snoop_valid, snoop_ready, snoop_source, snoop_address,
           snoop_is_store, snoop_size, snoop_data, trace_log_ready,
    input  trace_log_valid, trace_log_source, trace_log_address,
           trace_log_is_store, trace_log_size, trace_log_data, trace_log_cycle
  );

  // Collector side.
  modport slave (
    input  snoop_valid, snoop_ready, snoop_source, snoop_address,
           snoop_is_store, snoop_size, snoop_data, trace_log_ready,
    output trace_log_valid, trace_log_source, trace_log_address,
           trace_log_is_store, trace_log_size, trace_log_data, trace_log_cycle
  );

endinterface

// File: rtl/mem_trace_fifo.sv
// Generic synchronous FIFO; head is read from storage and zeroed when empty.
module mem_trace_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int OCC_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [OCC_W-1:0] occupancy_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             rd_fire;
  logic             wr_fire;

  assign empty_o     = (occ_q == '0);
  assign full_o      = (occ_q == OCC_W'(DEPTH));
  assign occupancy_o = occ_q;

  // A write into a full FIFO is only taken when the head leaves in the same cycle.
  assign rd_fire = rd_en_i & ~empty_o;
  assign wr_fire = wr_en_i & (~full_o | rd_fire);

  // Next pointers and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({wr_fire, rd_fire})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Pointer and occupancy registers; reset flushes the contents.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage array; contents need no reset because reads are gated by empty.
  always_ff @(posedge clock) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/mem_trace_collector.sv
// Snoops per-lane memory beats, packs each firing cycle into one snapshot and
// buffers snapshots for the trace logger. Lane widths come from mem_trace_pkg.
module mem_trace_collector
  import mem_trace_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int OCC_W = $clog2(DEPTH) + 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  mem_trace_collector_if.slave bus,
  output logic [OCC_W-1:0]    occupancy,
  output logic [DROP_W-1:0]   drop_count,
  output logic                overflow
);

  logic [NUM_LANES-1:0] fire_mask;
  entry_t               cap_entry;
  entry_t               head;
  logic [ENTRY_W-1:0]   fifo_rd_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 enq;
  logic                 deq;
  logic                 drop;

  logic [CYCLE_W-1:0]   cycle_q, cycle_d;
  logic [DROP_W-1:0]    drop_q, drop_d;
  logic                 ovf_q, ovf_d;

  assign fire_mask = bus.snoop_valid & bus.snoop_ready & {NUM_LANES{enable}};
  assign enq       = |fire_mask;
  assign deq       = ~fifo_empty & bus.trace_log_ready;
  assign drop      = enq & fifo_full & ~deq;

  // Pack the firing lanes into a snapshot; silent lanes are stored as zero.
  always_comb begin
    cap_entry       = '0;
    cap_entry.mask  = fire_mask;
    cap_entry.cycle = cycle_q;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (fire_mask[l]) begin
        cap_entry.lanes[l].source   = bus.snoop_source[l*SOURCE_W +: SOURCE_W];
        cap_entry.lanes[l].address  = bus.snoop_address[l*ADDR_W +: ADDR_W];
        cap_entry.lanes[l].is_store = bus.snoop_is_store[l];
        cap_entry.lanes[l].size     = bus.snoop_size[l*SIZE_W +: SIZE_W];
        cap_entry.lanes[l].data     = bus.snoop_data[l*DATA_W +: DATA_W];
      end
    end
  end

  mem_trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .wr_en_i     (enq & ~drop),
    .wr_data_i   (cap_entry),
    .rd_en_i     (deq),
    .rd_data_o   (fifo_rd_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .occupancy_o (occupancy)
  );

  assign head = fifo_rd_data;

  // Unpack the head snapshot onto the logger bus; all zero when empty.
  always_comb begin
    bus.trace_log_valid    = head.mask;
    bus.trace_log_cycle    = head.cycle;
    bus.trace_log_source   = '0;
    bus.trace_log_address  = '0;
    bus.trace_log_is_store = '0;
    bus.trace_log_size     = '0;
    bus.trace_log_data     = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      bus.trace_log_source[l*SOURCE_W +: SOURCE_W] = head.lanes[l].source;
      bus.trace_log_address[l*ADDR_W +: ADDR_W]    = head.lanes[l].address;
      bus.trace_log_is_store[l]                    = head.lanes[l].is_store;
      bus.trace_log_size[l*SIZE_W +: SIZE_W]       = head.lanes[l].size;
      bus.trace_log_data[l*DATA_W +: DATA_W]       = head.lanes[l].data;
    end
  end

  // Free-running cycle stamp and drop accounting next-state.
  always_comb begin
    cycle_d = cycle_q + CYCLE_W'(1);
    drop_d  = drop ? sat_inc(drop_q) : drop_q;
    ovf_d   = ovf_q | drop;
  end

  // Cycle stamp, saturating drop counter and sticky overflow flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_q <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      cycle_q <= cycle_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
    end
  end

  assign drop_count = drop_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_mem_trace_collector.sv
// Directed bench for mem_trace_collector.
module tb_mem_trace_collector;

  localparam int CW = 264;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [3:0]  occupancy;
  logic [31:0] drop_count;
  logic        overflow;

  int          n_vec;
  int          n_err;
  logic [63:0] cyc;
  logic [63:0] cap_cyc;
  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] exp_v;

  mem_trace_collector_if tif ();

  mem_trace_collector #(.DEPTH(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .bus        (tif),
    .occupancy  (occupancy),
    .drop_count (drop_count),
    .overflow   (overflow)
  );

  // Clock and watchdog.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // One clock; cyc tracks what the DUT cycle stamp should hold afterwards.
  task automatic step();
    logic r;
    r = reset;
    @(posedge clock);
    #1;
    cyc = r ? 64'd0 : cyc + 64'd1;
  endtask

  task automatic clear_snoop();
    tif.snoop_valid    = '0;
    tif.snoop_ready    = '0;
    tif.snoop_source   = '0;
    tif.snoop_address  = '0;
    tif.snoop_is_store = '0;
    tif.snoop_size     = '0;
    tif.snoop_data     = '0;
  endtask

  task automatic drive_lane(input int l, input logic [31:0] src, input logic [63:0] addr,
                            input logic st, input logic [7:0] sz, input logic [63:0] dat);
    tif.snoop_valid[l]           = 1'b1;
    tif.snoop_ready[l]           = 1'b1;
    tif.snoop_source[l*32 +: 32] = src;
    tif.snoop_address[l*64 +: 64] = addr;
    tif.snoop_is_store[l]        = st;
    tif.snoop_size[l*8 +: 8]     = sz;
    tif.snoop_data[l*64 +: 64]   = dat;
  endtask

  // Expected {mask, address bus} for a single-lane entry.
  function automatic logic [CW-1:0] one_lane(input int l, input logic [63:0] addr);
    logic [CW-1:0] v;
    v = '0;
    v[256 + l] = 1'b1;
    v[l*64 +: 64] = addr;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    cyc    = '0;
    reset  = 1'b1;
    enable = 1'b1;
    clear_snoop();
    tif.trace_log_ready = 1'b0;

    // Reset state.
    step(); step(); step();
    chk("rst_occ",   CW'(occupancy),           CW'(0));
    chk("rst_valid", CW'(tif.trace_log_valid), CW'(0));
    chk("rst_drop",  CW'(drop_count),          CW'(0));
    chk("rst_ovf",   CW'(overflow),            CW'(0));
    chk("rst_addr",  CW'(tif.trace_log_address), CW'(0));

    // Single fire on lane 2 at cycle 5.
    reset = 1'b0;
    tif.trace_log_ready = 1'b1;
    step(); step(); step(); step(); step();
    drive_lane(2, 32'h11, 64'h1000, 1'b1, 8'd2, 64'hAB);
    step();
    clear_snoop();
    chk("s_valid", CW'(tif.trace_log_valid),    CW'(4'b0100));
    chk("s_src",   CW'(tif.trace_log_source),   CW'(128'h11) << 64);
    chk("s_addr",  CW'(tif.trace_log_address),  CW'(256'h1000) << 128);
    chk("s_store", CW'(tif.trace_log_is_store), CW'(4'b0100));
    chk("s_size",  CW'(tif.trace_log_size),     CW'(32'h0002_0000));
    chk("s_data",  CW'(tif.trace_log_data),     CW'(256'hAB) << 128);
    chk("s_cycle", CW'(tif.trace_log_cycle),    CW'(64'd5));
    step();
    chk("s_empty_valid", CW'(tif.trace_log_valid), CW'(0));
    chk("s_empty_occ",   CW'(occupancy),           CW'(0));

    // All four lanes in one cycle -> one entry.
    for (int l = 0; l < 4; l++)
      drive_lane(l, 32'(l + 1), 64'h2000 + 64'(l * 16), l[0], 8'(l), 64'hD0 + 64'(l));
    cap_cyc = cyc;
    step();
    clear_snoop();
    chk("m_valid", CW'(tif.trace_log_valid), CW'(4'b1111));
    chk("m_addr",  CW'(tif.trace_log_address),
        CW'({64'h2030, 64'h2020, 64'h2010, 64'h2000}));
    chk("m_src",   CW'(tif.trace_log_source), CW'({32'h4, 32'h3, 32'h2, 32'h1}));
    chk("m_store", CW'(tif.trace_log_is_store), CW'(4'b1010));
    chk("m_size",  CW'(tif.trace_log_size), CW'({8'd3, 8'd2, 8'd1, 8'd0}));
    chk("m_data",  CW'(tif.trace_log_data),
        CW'({64'hD3, 64'hD2, 64'hD1, 64'hD0}));
    chk("m_cycle", CW'(tif.trace_log_cycle), CW'(cap_cyc));
    chk("m_occ",   CW'(occupancy), CW'(1));
    step();
    chk("m_drained", CW'(tif.trace_log_valid), CW'(0));

    // Gating: enable low for 3 fires, then a valid-but-not-ready lane.
    enable = 1'b0;
    drive_lane(0, 32'h77, 64'h7777, 1'b0, 8'd1, 64'h7);
    step(); step(); step();
    chk("g_occ",   CW'(occupancy), CW'(0));
    chk("g_valid", CW'(tif.trace_log_valid), CW'(0));
    enable = 1'b1;
    clear_snoop();
    tif.snoop_valid = 4'b0010;
    tif.snoop_ready = 4'b1101;
    step();
    clear_snoop();
    chk("nr_occ",   CW'(occupancy), CW'(0));
    chk("nr_valid", CW'(tif.trace_log_valid), CW'(0));

    // Backpressure: 10 single-lane fires into 8 slots.
    tif.trace_log_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      clear_snoop();
      drive_lane(i % 4, 32'(i), 64'h3000 + 64'(i), i[0], 8'd3, 64'h5000 + 64'(i));
      if (i < 8) exp_q.push_back(one_lane(i % 4, 64'h3000 + 64'(i)));
      step();
    end
    clear_snoop();
    chk("o_occ",  CW'(occupancy),  CW'(8));
    chk("o_drop", CW'(drop_count), CW'(2));
    chk("o_ovf",  CW'(overflow),   CW'(1));
    exp_v = exp_q.pop_front();
    chk("o_head", {tif.trace_log_valid, tif.trace_log_address}, exp_v);

    // Full with a simultaneous drain and fire: no drop.
    tif.trace_log_ready = 1'b1;
    drive_lane(0, 32'h40, 64'h4000, 1'b0, 8'd3, 64'h0);
    exp_q.push_back(one_lane(0, 64'h4000));
    step();
    clear_snoop();
    chk("f_occ",  CW'(occupancy),  CW'(8));
    chk("f_drop", CW'(drop_count), CW'(2));

    // Drain in capture order.
    for (int k = 0; k < 8; k++) begin
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      chk($sformatf("d_head%0d", k), {tif.trace_log_valid, tif.trace_log_address}, exp_v);
      step();
    end
    chk("d_occ",   CW'(occupancy), CW'(0));
    chk("d_valid", CW'(tif.trace_log_valid), CW'(0));
    chk("d_ovf",   CW'(overflow), CW'(1));
    chk("d_left",  CW'(exp_q.size()), CW'(0));

    // Reset mid-drain with 5 entries held.
    tif.trace_log_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      clear_snoop();
      drive_lane(3, 32'h60, 64'h6000 + 64'(i), 1'b1, 8'd3, 64'h6);
      step();
    end
    clear_snoop();
    chk("r_occ5",  CW'(occupancy),  CW'(5));
    chk("r_drop2", CW'(drop_count), CW'(2));
    tif.trace_log_ready = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("r_occ",   CW'(occupancy), CW'(0));
    chk("r_valid", CW'(tif.trace_log_valid), CW'(0));
    chk("r_addr",  CW'(tif.trace_log_address), CW'(0));
    chk("r_cycle", CW'(tif.trace_log_cycle), CW'(0));
    chk("r_drop",  CW'(drop_count), CW'(0));
    chk("r_ovf",   CW'(overflow), CW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
